sc_stream_arbiter: RTL and testbench
====================================

# sc_stream_arbiter

Packet-level arbiter that shares one Schmidl-Cox synchronizer datapath between two 32-bit AXI-stream requesters. It sits between two sample sources and the `schmidl_cox` core and routes each core output packet back to the requester that sent the matching input packet. Arbitration works on whole packets only. Mode is set over the settings bus.

## Interface
- `WIDTH`, 32: sample bus width (sc16 I/Q).
- `SR_ARB_BASE`, 160: settings address of the mode register.
- `TAG_FIFO_LOG2`, 3: log2 depth of the grant-tag FIFO (8 entries).

- `clk`  in  1  compute-engine clock; all logic is synchronous to it.
- `reset`  in  1  asynchronous, active-low reset.
- `set_stb`, `set_addr[7:0]`, `set_data[31:0]`  in  settings bus.
- `in0_tdata`/`in1_tdata`  in  WIDTH  requester sample data.
- `in0_tlast`, `in0_tvalid`, `in1_tlast`, `in1_tvalid`  in  1  requester framing and valid.
- `in0_tready`, `in1_tready`  out  1  requester ready.
- `m_tdata`  out  WIDTH; `m_tlast`, `m_tvalid`  out  1; `m_tready`  in  1  to core input.
- `s_tdata`  in  WIDTH; `s_tlast`, `s_tvalid`  in  1; `s_tready`  out  1  from core output.
- `out0_*`, `out1_*`  out  WIDTH/1/1; `out*_tready`  in  1  per-requester return streams.
- `pkt_cnt0`, `pkt_cnt1`  out  16  completed input packets granted per requester.
- `busy`  out  1  high when not IDLE or the tag FIFO is non-empty.

## Operation
- **Mode register** (`set_addr == SR_ARB_BASE`):
  - bit0 = enable in0, bit1 = enable in1.
  - bit2 = fixed priority (in0 wins); 0 = round-robin.
  - Reset value 3'b011.
  - Writes take effect at the next IDLE decision and never cut a packet in flight.
- **Core contract:** exactly one output packet per input packet, in order.
- **Input FSM states:** IDLE, GNT0, GNT1.
- **IDLE:** candidate x has `inx_tvalid` high and is enabled. Grant only if the tag FIFO is not full.
  - Both candidates, round-robin: grant the one not equal to `last_grant`.
  - Both candidates, fixed priority: grant in0.
  - On grant: push tag x into the FIFO, set `last_grant` = x, go to GNTx.
- **GNTx** (combinational mux):
  - `m_tdata`, `m_tlast`, `m_tvalid` follow inx.
  - `inx_tready` = `m_tready`; the other requester's tready = 0.
  - On a handshake with `m_tlast` (`m_tvalid & m_tready & m_tlast`): increment `pkt_cnt x`, return to IDLE.
- **Output demux:** the FIFO head tag h selects the destination.
  - `outh_*` = `s_*`; `s_tready` = `outh_tready`; the other output's tvalid = 0.
  - The FIFO pops on an `s` handshake with `s_tlast`.
  - FIFO empty: `s_tready` = 0 and both out tvalid = 0.
- **FIFO push and pop in the same cycle:** occupancy unchanged, both take effect.
- **Counters:** 16-bit, wrap 0xFFFF -> 0.
- **Disabling a requester during its grant:** the packet completes; it is then ignored.
- **Single-beat packet** (tlast on first beat): legal, one tag, one count.

## Timing
- **Reset values (while `reset` low):**
  - state IDLE, `last_grant` = 1 (in0 wins first round-robin), FIFO empty.
  - All tready 0, `m_tvalid`/`out*_tvalid` 0, `m_tdata`/`m_tlast` 0.
  - counters 0, `busy` 0, mode 3'b011.
- **Grant latency:** IDLE samples tvalid; GNTx is entered on the next edge. The first beat can transfer one cycle after tvalid is first seen.
- **Packet gap:** one IDLE bubble cycle after each packet; no back-to-back grant in the same cycle as tlast.
- **Datapath latency:** zero through both mux and demux; no data registers on the path.
- **Tag visibility:** a tag pushed at cycle n is visible at the FIFO head at cycle n+1. This is always before the core can emit, since the core latency is ≥1.
- **AXI rules:** tvalid must never depend on tready. Once `m_tvalid` is asserted in GNTx it is held by the requester's own contract.
- **Reset mid-packet:** the FSM and FIFO clear immediately. Partial packets are the upstream's responsibility.

## Test plan
- in0 only, three 4-beat packets, `m_tready`=1, core modelled as pass-through -> all 12 beats appear on out0, out1 silent, `pkt_cnt0`=3, one IDLE bubble between packets.
- Both valid continuously, round-robin, 2-beat packets -> grant order in0, in1, in0, in1; out streams carry matching data; both counters equal 2 after 4 packets.
- Mode=3'b111 (fixed priority), both valid for 4 packets -> in0 granted every time, `in1_tready` stays 0, `pkt_cnt1`=0.
- Core stalled (`s_tready` path blocked by `out0_tready`=0) while 9 single-beat in0 packets offered -> exactly 8 granted, 9th waits in IDLE until one pop, then granted.
- Mode written to 3'b010 mid-packet on in0 -> current in0 packet completes (tlast passed), later in0 packets ignored, in1 served.
- Assert `reset` low during beat 2 of a 4-beat packet -> all tready/tvalid 0 that cycle, counters 0, next in0 packet granted first after release.

Source files
------------

// File: rtl/sc_stream_arbiter_if.sv
// sc_stream_arbiter_if: one AXI-stream link (data, last, valid, ready) with source/sink views.
interface sc_stream_arbiter_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tlast, tvalid, input tready);
  modport slave (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/sc_stream_arbiter.sv
// sc_stream_arbiter: packet-level arbiter sharing one Schmidl-Cox core between two requesters,
// routing each core output packet back to its originator through a grant-tag FIFO.
module sc_stream_arbiter #(
  parameter int WIDTH = 32,
  parameter logic [7:0] SR_ARB_BASE = 8'd160,
  parameter int TAG_FIFO_LOG2 = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set_stb,
  input  logic [7:0] set_addr,
  input  logic [31:0] set_data,
  sc_stream_arbiter_if.slave in0,
  sc_stream_arbiter_if.slave in1,
  sc_stream_arbiter_if.master m,
  sc_stream_arbiter_if.slave s,
  sc_stream_arbiter_if.master out0,
  sc_stream_arbiter_if.master out1,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam int L = TAG_FIFO_LOG2;
  localparam int DEPTH = 1 << L;
  logic [1:0] state;
  logic [2:0] mode;
  logic last_grant;
  logic [L:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] tags;
  logic gnt0, gnt1, cand0, cand1, pick1, grant, fifo_empty, fifo_full, head, pop, m_done;
  logic [WIDTH-1:0] in_data;
  logic unused_set;
  assign unused_set = ^set_data[31:3];
  always_comb begin
    gnt0 = state == GNT0;
    gnt1 = state == GNT1;
    cand0 = in0.tvalid & mode[0];
    cand1 = in1.tvalid & mode[1];
    // in1 wins only when alone, or on a round-robin tie after in0 was served last
    pick1 = cand1 & (~cand0 | (~mode[2] & ~last_grant));
    fifo_empty = wr_ptr == rd_ptr;
    fifo_full = (wr_ptr[L] != rd_ptr[L]) && (wr_ptr[L-1:0] == rd_ptr[L-1:0]);
    grant = (state == IDLE) & ~fifo_full & (cand0 | cand1);
    head = tags[rd_ptr[L-1:0]];
    in_data = gnt1 ? in1.tdata : in0.tdata;
    m.tdata = (gnt0 | gnt1) ? in_data : '0;
    m.tlast = gnt0 ? in0.tlast : gnt1 & in1.tlast;
    m.tvalid = gnt0 ? in0.tvalid : gnt1 & in1.tvalid;
    in0.tready = gnt0 & m.tready;
    in1.tready = gnt1 & m.tready;
    m_done = m.tvalid & m.tready & m.tlast;
    s.tready = ~fifo_empty & (head ? out1.tready : out0.tready);
    out0.tdata = s.tdata;
    out0.tlast = s.tlast;
    out0.tvalid = ~fifo_empty & ~head & s.tvalid;
    out1.tdata = s.tdata;
    out1.tlast = s.tlast;
    out1.tvalid = ~fifo_empty & head & s.tvalid;
    pop = s.tvalid & s.tready & s.tlast;
    busy = (state != IDLE) | ~fifo_empty;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mode <= 3'b011;
      last_grant <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (set_stb && set_addr == SR_ARB_BASE) mode <= set_data[2:0];
      if (grant) begin
        state <= pick1 ? GNT1 : GNT0;
        last_grant <= pick1;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (m_done || !(gnt0 || gnt1)) state <= IDLE;
      if (gnt0 && m_done) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (gnt1 && m_done) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (grant) tags[wr_ptr[L-1:0]] <= pick1;
  end
endmodule

// File: tb/tb_sc_stream_arbiter.sv
// tb_sc_stream_arbiter: directed packets per requester, pass-through core model, per-output
// scoreboard queues checked by an independent monitor.
module tb_sc_stream_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic set_stb = 0;
  logic [7:0] set_addr = 0;
  logic [31:0] set_data = 0;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic busy;
  sc_stream_arbiter_if #(.WIDTH(32)) in0 ();
  sc_stream_arbiter_if #(.WIDTH(32)) in1 ();
  sc_stream_arbiter_if #(.WIDTH(32)) m ();
  sc_stream_arbiter_if #(.WIDTH(32)) s ();
  sc_stream_arbiter_if #(.WIDTH(32)) out0 ();
  sc_stream_arbiter_if #(.WIDTH(32)) out1 ();
  sc_stream_arbiter #(.WIDTH(32), .SR_ARB_BASE(8'd160), .TAG_FIFO_LOG2(3)) dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in0(in0), .in1(in1), .m(m), .s(s), .out0(out0), .out1(out1),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int c1 = 0;
  bit hs0, hs1, mid0, mid1, saw_rdy1;
  logic [32:0] q0[$], q1[$], e0[$], e1[$], cq[$];
  int glog[$];
  int hc0[$];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pkt(input int p, input int n, input logic [31:0] base, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      logic [32:0] b;
      b = {i == n - 1, base + i};
      if (p == 0) q0.push_back(b); else q1.push_back(b);
      if (expect_it) begin
        if (p == 0) e0.push_back(b); else e1.push_back(b);
      end
    end
  endtask
  task automatic set_mode(input logic [2:0] v);
    @(posedge clk); #1;
    set_stb = 1; set_addr = 8'd160; set_data = {29'd0, v};
    @(posedge clk); #1;
    set_stb = 0;
  endtask
  task automatic wait_done(input string n);
    int k = 0;
    tick(2);
    while ((e0.size() != 0 || e1.size() != 0 || busy) && k < 400) begin
      tick(1);
      k++;
    end
    chk({n, " timeout"}, k >= 400, 0);
  endtask
  always @(posedge clk) cyc++;
  // core model: accepts every offered beat, replays it on s at least one cycle later
  always @(posedge clk) begin
    if (!reset) cq.delete();
    else begin
      if (s.tvalid && s.tready && cq.size() > 0) void'(cq.pop_front());
      if (m.tvalid && m.tready) cq.push_back({m.tlast, m.tdata});
    end
    s.tvalid <= cq.size() > 0;
    if (cq.size() > 0) {s.tlast, s.tdata} <= cq[0];
  end
  always @(posedge clk) begin
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      {in0.tlast, in0.tdata} = q0[0]; in0.tvalid = 1;
    end else begin
      in0.tlast = 0; in0.tdata = 0; in0.tvalid = 0;
    end
    if (q1.size() > 0) begin
      {in1.tlast, in1.tdata} = q1[0]; in1.tvalid = 1;
    end else begin
      in1.tlast = 0; in1.tdata = 0; in1.tvalid = 0;
    end
  end
  always @(negedge clk) begin
    hs0 = in0.tvalid && in0.tready;
    hs1 = in1.tvalid && in1.tready;
    if (!reset) begin
      mid0 = 0; mid1 = 0;
    end
    if (in1.tready) saw_rdy1 = 1;
    if (hs0) begin
      if (!mid0) glog.push_back(0);
      mid0 = !in0.tlast;
      hc0.push_back(cyc);
    end
    if (hs1) begin
      if (!mid1) glog.push_back(1);
      mid1 = !in1.tlast;
    end
    if (out0.tvalid && out0.tready) begin
      if (e0.size() == 0) begin
        checks++; errors++;
        $display("FAIL out0 unexpected beat: got %0h expected none", {out0.tlast, out0.tdata});
      end else chk("out0 beat", {out0.tlast, out0.tdata}, e0.pop_front());
    end
    if (out1.tvalid && out1.tready) begin
      if (e1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1 unexpected beat: got %0h expected none", {out1.tlast, out1.tdata});
      end else chk("out1 beat", {out1.tlast, out1.tdata}, e1.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    in0.tvalid = 0; in0.tlast = 0; in0.tdata = 0;
    in1.tvalid = 0; in1.tlast = 0; in1.tdata = 0;
    m.tready = 1; out0.tready = 1; out1.tready = 1;
    #2 reset = 0;
    tick(3);
    chk("rst in0_tready", in0.tready, 0);
    chk("rst in1_tready", in1.tready, 0);
    chk("rst m_tvalid", m.tvalid, 0);
    chk("rst m_tdata", m.tdata, 0);
    chk("rst m_tlast", m.tlast, 0);
    chk("rst s_tready", s.tready, 0);
    chk("rst out0_tvalid", out0.tvalid, 0);
    chk("rst out1_tvalid", out1.tvalid, 0);
    chk("rst pkt_cnt0", pkt_cnt0, 0);
    chk("rst pkt_cnt1", pkt_cnt1, 0);
    chk("rst busy", busy, 0);
    reset = 1;
    tick(2);
    glog.delete();
    for (int p = 0; p < 2; p++) begin
      pkt(0, 2, 32'h1000 + 16 * p, 1);
      pkt(1, 2, 32'h2000 + 16 * p, 1);
    end
    c0 += 2; c1 += 2;
    wait_done("rr");
    chk("rr grant count", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr grant order", i < glog.size() ? glog[i] : 9, i % 2);
    chk("rr pkt_cnt0", pkt_cnt0, c0);
    chk("rr pkt_cnt1", pkt_cnt1, c1);
    hc0.delete();
    for (int p = 0; p < 3; p++) pkt(0, 4, 32'h3000 + 16 * p, 1);
    c0 += 3;
    wait_done("in0 only");
    chk("in0 only beats", hc0.size(), 12);
    if (hc0.size() == 12)
      for (int i = 1; i < 12; i++) chk("in0 only beat spacing", hc0[i] - hc0[i-1], (i % 4 == 0) ? 2 : 1);
    chk("in0 only pkt_cnt0", pkt_cnt0, c0);
    chk("in0 only pkt_cnt1", pkt_cnt1, c1);
    set_mode(3'b111);
    tick(1);
    saw_rdy1 = 0;
    for (int p = 0; p < 4; p++) begin
      pkt(0, 2, 32'h4000 + 16 * p, 1);
      pkt(1, 2, 32'h5000 + 16 * p, 1);
    end
    k = 0;
    while (pkt_cnt0 != 16'(c0 + 4) && k < 200) begin
      tick(1);
      k++;
    end
    chk("fixed wait timeout", k >= 200, 0);
    chk("fixed in1_tready seen", saw_rdy1, 0);
    chk("fixed pkt_cnt1", pkt_cnt1, c1);
    set_mode(3'b011);
    c0 += 4; c1 += 4;
    wait_done("fixed");
    chk("fixed pkt_cnt0", pkt_cnt0, c0);
    chk("fixed drain pkt_cnt1", pkt_cnt1, c1);
    out0.tready = 0;
    for (int p = 0; p < 9; p++) pkt(0, 1, 32'h6000 + p, 1);
    tick(40);
    chk("full granted", pkt_cnt0, c0 + 8);
    chk("full 9th waiting", q0.size(), 1);
    chk("full busy", busy, 1);
    chk("full in0_tready", in0.tready, 0);
    out0.tready = 1;
    c0 += 9;
    wait_done("full");
    chk("full pkt_cnt0", pkt_cnt0, c0);
    hc0.delete();
    pkt(0, 4, 32'h7000, 1);
    k = 0;
    while (hc0.size() == 0 && k < 50) begin
      tick(1);
      k++;
    end
    chk("disable wait timeout", k >= 50, 0);
    set_mode(3'b010);
    tick(1);
    pkt(0, 4, 32'h7100, 0);
    pkt(1, 4, 32'h8000, 1);
    c0 += 1; c1 += 1;
    wait_done("disable");
    chk("disable pkt_cnt0", pkt_cnt0, c0);
    chk("disable pkt_cnt1", pkt_cnt1, c1);
    chk("disable in0 ignored", q0.size(), 4);
    q0.delete();
    set_mode(3'b011);
    tick(2);
    out0.tready = 0;
    hc0.delete();
    pkt(0, 4, 32'h9000, 0);
    k = 0;
    while (hc0.size() == 0 && k < 50) begin
      tick(1);
      k++;
    end
    chk("reset wait timeout", k >= 50, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst in0_tready", in0.tready, 0);
    chk("midrst m_tvalid", m.tvalid, 0);
    chk("midrst s_tready", s.tready, 0);
    chk("midrst out0_tvalid", out0.tvalid, 0);
    chk("midrst pkt_cnt0", pkt_cnt0, 0);
    chk("midrst pkt_cnt1", pkt_cnt1, 0);
    chk("midrst busy", busy, 0);
    q0.delete();
    tick(1);
    reset = 1;
    c0 = 1; c1 = 1;
    out0.tready = 1;
    tick(1);
    glog.delete();
    pkt(0, 2, 32'hA000, 1);
    pkt(1, 2, 32'hB000, 1);
    wait_done("after reset");
    chk("after reset first grant", glog.size() > 0 ? glog[0] : 9, 0);
    chk("after reset pkt_cnt0", pkt_cnt0, c0);
    chk("after reset pkt_cnt1", pkt_cnt1, c1);
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
